// File: rtl/rs_pkg.sv
// Shared types and helpers for the multi-issue reservation station.
// Packet type at the default packet width and the replay-iteration bit lookup.
package rs_pkg;

  localparam int RS_DEPTH    = 8;
  localparam int RS_NUM_PE   = 4;
  localparam int RS_PKT_W    = 30;
  localparam int RS_ITER_W   = 3;
  localparam int RS_ITER_LSB = 7;

  typedef logic [RS_PKT_W-1:0] rs_pkt_t;

  // Returns the mask bit selected by iter; an iteration outside the mask never matches.
  function automatic logic iter_bit(input rs_pkt_t pkt, input int unsigned iter,
                                    input int unsigned lsb, input int unsigned width);
    rs_pkt_t shifted;
    shifted = pkt >> (lsb + iter);
    if (iter < width) return shifted[0];
    return 1'b0;
  endfunction

endpackage

// File: rtl/rs_oldest_pick.sv
// Selects the single oldest entry among a candidate mask using the age matrix.
// older[i][j]=1 means entry i was written before entry j.
module rs_oldest_pick #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]            cand,
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
  output logic [DEPTH-1:0]            pick
);

  // An entry wins when it is older than every other candidate.
  always_comb begin
    pick = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pick[i] = cand[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && cand[j] && !older[i][j]) pick[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rs_multi_dispatch.sv
// Multi-issue reservation station: buffers task packets and issues up to NUM_PE
// per cycle, oldest-first, with entries tagged for the current replay iteration first.
// Optional feature macro: RS_BYPASS_EN (empty-RS same-cycle bypass to lowest idle PE).
// Handshake: a packet transfers on a clk edge where in_valid && in_ready; in_ready
// depends only on registered state. out_valid[i] is a fire-and-forget pulse, pe_idle[i]
// being the grant.
module rs_multi_dispatch
  import rs_pkg::*;
#(
  parameter int          DEPTH    = RS_DEPTH,
  parameter int          NUM_PE   = RS_NUM_PE,
  parameter int          PKT_W    = RS_PKT_W,
  parameter int unsigned ITER_W   = RS_ITER_W,
  parameter int unsigned ITER_LSB = RS_ITER_LSB,
  localparam int         RI_W     = (ITER_W > 1) ? $clog2(ITER_W) : 1,
  localparam int         OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PKT_W-1:0]        in_packet,
  input  logic [RI_W-1:0]         replay_iter,
  input  logic [NUM_PE-1:0]       pe_idle,
  output logic [NUM_PE-1:0]       out_valid,
  output logic [NUM_PE*PKT_W-1:0] out_packet,
  output logic                    rs_empty,
  output logic                    rs_full,
  output logic [OCC_W-1:0]        occupancy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PE_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic [DEPTH-1:0]            valid_q;
  logic [PKT_W-1:0]            pkt_q [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] older_q;
  logic [OCC_W-1:0]            occ_q;
  logic                        empty_q;
  logic                        full_q;

  logic [DEPTH-1:0] pref;
  logic [DEPTH-1:0] cand;
  logic [DEPTH-1:0] stage_cand [NUM_PE];
  logic [DEPTH-1:0] pick [NUM_PE];
  logic [DEPTH-1:0] issued;
  logic [PE_W-1:0]  rank;
  logic             bypass_fire;
  logic             accept;
  logic [IDX_W-1:0] free_idx;
  logic [OCC_W-1:0] issue_cnt;
  logic [OCC_W-1:0] occ_next;
  logic [DEPTH-1:0] valid_next;

  // Candidate set: preferred-class entries if any exist, otherwise all valid entries.
  always_comb begin
    pref = '0;
    for (int e = 0; e < DEPTH; e++) begin
      pref[e] = valid_q[e] && iter_bit(rs_pkt_t'(pkt_q[e]), 32'(replay_iter), ITER_LSB, ITER_W);
    end
    cand = (|pref) ? pref : valid_q;
  end

  // Cascade of oldest-pickers: stage k yields the k-th oldest candidate.
  for (genvar k = 0; k < NUM_PE; k++) begin : g_pick
    if (k == 0) begin : g_first
      assign stage_cand[k] = cand;
    end else begin : g_next
      assign stage_cand[k] = stage_cand[k-1] & ~pick[k-1];
    end
    rs_oldest_pick #(.DEPTH(DEPTH)) u_pick (
      .cand  (stage_cand[k]),
      .older (older_q),
      .pick  (pick[k])
    );
  end

  // Issue: the n-th idle PE (ascending index) receives the n-th oldest candidate.
  always_comb begin
    issued      = '0;
    out_valid   = '0;
    out_packet  = '0;
    rank        = '0;
    bypass_fire = 1'b0;
    if (!reset) begin
      for (int i = 0; i < NUM_PE; i++) begin
        if (pe_idle[i] && (|pick[rank])) begin
          out_valid[i] = 1'b1;
          issued       = issued | pick[rank];
          for (int e = 0; e < DEPTH; e++) begin
            if (pick[rank][e]) out_packet[i*PKT_W +: PKT_W] = out_packet[i*PKT_W +: PKT_W] | pkt_q[e];
          end
          rank = rank + 1'b1;
        end
      end
`ifdef RS_BYPASS_EN
      // With nothing to issue, an offered packet goes straight to the lowest idle PE.
      if (!(|cand) && in_valid) begin
        for (int i = 0; i < NUM_PE; i++) begin
          if (pe_idle[i] && !bypass_fire) begin
            out_valid[i]                = 1'b1;
            out_packet[i*PKT_W +: PKT_W] = in_packet;
            bypass_fire                 = 1'b1;
          end
        end
      end
`endif
    end
  end

  assign in_ready = !reset && !full_q;
  assign accept   = in_valid && in_ready && !bypass_fire;

  // Free-slot finder: lowest-index invalid entry.
  always_comb begin
    free_idx = '0;
    for (int e = DEPTH - 1; e >= 0; e--) begin
      if (!valid_q[e]) free_idx = IDX_W'(e);
    end
  end

  // Next occupancy and valid vector from accepted and issued packets.
  always_comb begin
    issue_cnt = '0;
    for (int e = 0; e < DEPTH; e++) issue_cnt = issue_cnt + OCC_W'(issued[e]);
    occ_next   = occ_q + OCC_W'(accept) - issue_cnt;
    valid_next = valid_q & ~issued;
    if (accept) valid_next[free_idx] = 1'b1;
  end

  // Control state: valid bits, age matrix, occupancy and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      older_q <= '0;
      occ_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      valid_q <= valid_next;
      occ_q   <= occ_next;
      empty_q <= (occ_next == '0);
      full_q  <= (occ_next == OCC_W'(DEPTH));
      if (accept) begin
        // New entry is younger than every entry currently valid.
        for (int j = 0; j < DEPTH; j++) begin
          older_q[free_idx][j] <= 1'b0;
          older_q[j][free_idx] <= valid_q[j];
        end
      end
    end
  end

  // Packet storage; contents are qualified by valid_q so need no reset.
  always_ff @(posedge clk) begin
    if (accept) pkt_q[free_idx] <= in_packet;
  end

  assign rs_empty  = empty_q;
  assign rs_full   = full_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_rs_multi_dispatch.sv
// Directed bench for rs_multi_dispatch: ordering, replay priority, full/backpressure,
// reset, and (with RS_BYPASS_EN) the same-cycle bypass.
module tb_rs_multi_dispatch;
  import rs_pkg::*;

  localparam int DEPTH  = 8;
  localparam int NUM_PE = 4;
  localparam int PKT_W  = 30;
  localparam int RI_W   = 2;
  localparam int OCC_W  = 4;

  logic                    clk;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic [PKT_W-1:0]        in_packet;
  logic [RI_W-1:0]         replay_iter;
  logic [NUM_PE-1:0]       pe_idle;
  logic [NUM_PE-1:0]       out_valid;
  logic [NUM_PE*PKT_W-1:0] out_packet;
  logic                    rs_empty;
  logic                    rs_full;
  logic [OCC_W-1:0]        occupancy;

  int passes = 0;
  int checks = 0;
  int fails  = 0;

  logic [PKT_W-1:0] a, b, c, z, x9;
  logic [PKT_W-1:0] p [8];
  logic [PKT_W-1:0] q [3];

  rs_multi_dispatch dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_packet   (in_packet),
    .replay_iter (replay_iter),
    .pe_idle     (pe_idle),
    .out_valid   (out_valid),
    .out_packet  (out_packet),
    .rs_empty    (rs_empty),
    .rs_full     (rs_full),
    .occupancy   (occupancy)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PKT_W-1:0] pe_pkt(input int i);
    return out_packet[i*PKT_W +: PKT_W];
  endfunction

  function automatic logic [PKT_W-1:0] mk(input int id, input logic [2:0] mask);
    logic [PKT_W-1:0] v;
    v        = '0;
    v[29:10] = 20'(id);
    v[9:7]   = mask;
    v[6:0]   = 7'h2A;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [PKT_W-1:0] pkt);
    in_valid  = 1'b1;
    in_packet = pkt;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_packet = '0; replay_iter = '0; pe_idle = 4'hF;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pkt0", 32'(pe_pkt(0)), 32'd0);
    chk("rst_empty", 32'(rs_empty), 32'd1);
    chk("rst_full", 32'(rs_full), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Oldest-first across idle PEs 0 and 2
    pe_idle = 4'b0000;
    a = mk(1, 3'b000); b = mk(2, 3'b000); c = mk(3, 3'b000);
    enq(a); enq(b); enq(c);
    chk("t1_occ3", 32'(occupancy), 32'd3);
    chk("t1_not_empty", 32'(rs_empty), 32'd0);
    pe_idle = 4'b0101;
    #1;
    chk("t1_out_valid", 32'(out_valid), 32'b0101);
    chk("t1_pe0", 32'(pe_pkt(0)), 32'(a));
    chk("t1_pe2", 32'(pe_pkt(2)), 32'(b));
    chk("t1_pe1_zero", 32'(pe_pkt(1)), 32'd0);
    tick();
    chk("t1_occ1", 32'(occupancy), 32'd1);
    pe_idle = 4'b0001;
    #1;
    chk("t1_pe0_c", 32'(pe_pkt(0)), 32'(c));
    tick();
    chk("t1_empty", 32'(rs_empty), 32'd1);
    pe_idle = 4'b0000;

    // Replay-iteration priority
    a = mk(4, 3'b000); b = mk(5, 3'b010);
    enq(a); enq(b);
    replay_iter = 2'd1; pe_idle = 4'b0001;
    #1;
    chk("t2_out_valid", 32'(out_valid), 32'b0001);
    chk("t2_pref_b", 32'(pe_pkt(0)), 32'(b));
    tick();
    replay_iter = 2'd0;
    #1;
    chk("t2_then_a", 32'(pe_pkt(0)), 32'(a));
    tick();
    chk("t2_occ0", 32'(occupancy), 32'd0);

    // Preferred class restricts issue; out-of-range iteration is plain oldest-first
    pe_idle = 4'b0000;
    a = mk(6, 3'b000); b = mk(7, 3'b100);
    enq(a); enq(b);
    replay_iter = 2'd2; pe_idle = 4'b0011;
    #1;
    chk("t2b_only_pref", 32'(out_valid), 32'b0001);
    chk("t2b_pe0_b", 32'(pe_pkt(0)), 32'(b));
    chk("t2b_pe1_zero", 32'(pe_pkt(1)), 32'd0);
    replay_iter = 2'd3;
    #1;
    chk("t2b_iter3_valid", 32'(out_valid), 32'b0011);
    chk("t2b_iter3_pe0", 32'(pe_pkt(0)), 32'(a));
    chk("t2b_iter3_pe1", 32'(pe_pkt(1)), 32'(b));
    tick();
    chk("t2b_occ0", 32'(occupancy), 32'd0);
    replay_iter = 2'd0; pe_idle = 4'b0000;

    // Fill to full, hold a 9th offer, then drain four
    for (int k = 0; k < 8; k++) begin
      p[k] = mk(16 + k, 3'b000);
      enq(p[k]);
    end
    chk("t3_full", 32'(rs_full), 32'd1);
    chk("t3_in_ready0", 32'(in_ready), 32'd0);
    chk("t3_occ8", 32'(occupancy), 32'd8);
    x9 = mk(40, 3'b000);
    in_valid = 1'b1; in_packet = x9;
    tick();
    chk("t3_held_occ8", 32'(occupancy), 32'd8);
    pe_idle = 4'b1111;
    #1;
    chk("t3_out_valid", 32'(out_valid), 32'b1111);
    for (int k = 0; k < 4; k++) chk($sformatf("t3_pe%0d", k), 32'(pe_pkt(k)), 32'(p[k]));
    tick();
    chk("t3_occ4", 32'(occupancy), 32'd4);
    chk("t3_not_full", 32'(rs_full), 32'd0);
    pe_idle = 4'b0000;
    #1;
    chk("t3_in_ready1", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t3_occ5", 32'(occupancy), 32'd5);

    // Full with one idle PE: one issue, no enqueue
    for (int k = 0; k < 3; k++) begin
      q[k] = mk(50 + k, 3'b000);
      enq(q[k]);
    end
    chk("t4_full", 32'(rs_full), 32'd1);
    in_valid = 1'b1; in_packet = mk(60, 3'b000); pe_idle = 4'b0001;
    #1;
    chk("t4_in_ready0", 32'(in_ready), 32'd0);
    chk("t4_out_valid", 32'(out_valid), 32'b0001);
    chk("t4_pe0_p4", 32'(pe_pkt(0)), 32'(p[4]));
    tick();
    chk("t4_occ7", 32'(occupancy), 32'd7);
    chk("t4_not_full", 32'(rs_full), 32'd0);

    // Simultaneous enqueue and issue leaves occupancy unchanged
    in_packet = mk(61, 3'b000);
    #1;
    chk("t4_pe0_p5", 32'(pe_pkt(0)), 32'(p[5]));
    tick();
    in_valid = 1'b0;
    chk("t4_occ7_again", 32'(occupancy), 32'd7);

    // Reset mid-stream with five valid entries
    pe_idle = 4'b0011;
    #1;
    chk("t5_pe0_p6", 32'(pe_pkt(0)), 32'(p[6]));
    chk("t5_pe1_p7", 32'(pe_pkt(1)), 32'(p[7]));
    tick();
    chk("t5_occ5", 32'(occupancy), 32'd5);
    pe_idle = 4'b1111; reset = 1'b1;
    #1;
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t5_empty", 32'(rs_empty), 32'd1);
    chk("t5_occ0", 32'(occupancy), 32'd0);
    chk("t5_out_valid0", 32'(out_valid), 32'd0);
    reset = 1'b0;
    #1;
    chk("t5_post_out_valid", 32'(out_valid), 32'd0);
    chk("t5_post_full", 32'(rs_full), 32'd0);

    // Empty RS with an offer and PE1 idle
    z = mk(70, 3'b000);
    pe_idle = 4'b0010; in_valid = 1'b1; in_packet = z;
    #1;
`ifdef RS_BYPASS_EN
    chk("t6_bypass_valid", 32'(out_valid), 32'b0010);
    chk("t6_bypass_pkt", 32'(pe_pkt(1)), 32'(z));
    tick();
    in_valid = 1'b0;
    chk("t6_occ0", 32'(occupancy), 32'd0);
    chk("t6_empty", 32'(rs_empty), 32'd1);
`else
    chk("t6_no_bypass", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("t6_occ1", 32'(occupancy), 32'd1);
    chk("t6_issue_valid", 32'(out_valid), 32'b0010);
    chk("t6_issue_pkt", 32'(pe_pkt(1)), 32'(z));
    tick();
    chk("t6_occ0", 32'(occupancy), 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
